// File: rtl/music_pkg.sv
// Shared note/duration types for the music player blocks.
package music_pkg;
  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;

  typedef logic [NOTE_W-1:0] note_t;
  typedef logic [DUR_W-1:0]  dur_t;

  localparam note_t REST_NOTE = '0;
endpackage

// File: rtl/voice_slot.sv
// One note-player voice: note register, beat countdown, active flag, load pulse.
// With VOICE_STEAL_EN the remaining count is exported for the steal selector.
module voice_slot #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              load,
  input  logic              tick,
  input  logic [NOTE_W-1:0] note_in,
  input  logic [DUR_W-1:0]  dur_in,
`ifdef VOICE_STEAL_EN
  output logic [DUR_W-1:0]  rem_out,
`endif
  output logic              active,
  output logic              active_nxt,
  output logic              load_pulse,
  output logic [NOTE_W-1:0] note
);
  logic [DUR_W-1:0] remaining, rem_nxt;

  // A load wins over a tick so a freshly loaded voice is not decremented.
  always_comb begin
    active_nxt = active;
    rem_nxt    = remaining;
    if (flush) begin
      active_nxt = 1'b0;
      rem_nxt    = '0;
    end else if (load) begin
      active_nxt = 1'b1;
      rem_nxt    = dur_in;
    end else if (tick && active) begin
      if (remaining > DUR_W'(1)) begin
        rem_nxt = remaining - DUR_W'(1);
      end else begin
        active_nxt = 1'b0;
        rem_nxt    = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active     <= 1'b0;
      remaining  <= '0;
      load_pulse <= 1'b0;
      note       <= '0;
    end else begin
      active     <= active_nxt;
      remaining  <= rem_nxt;
      load_pulse <= load && !flush;
      if (load && !flush) note <= note_in;
    end
  end

`ifdef VOICE_STEAL_EN
  assign rem_out = remaining;
`endif
endmodule

// File: rtl/voice_allocator.sv
// Schedules offered notes onto a pool of voice slots; lowest free voice wins.
// Optional VOICE_STEAL_EN: a full pool replaces the voice with the least remaining time.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_W     = music_pkg::NOTE_W,
  parameter int DUR_W      = music_pkg::DUR_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         play,
  input  logic                         flush,
  input  logic                         beat,
  input  logic                         note_valid,
  output logic                         note_ready,
  input  logic [NOTE_W-1:0]            note,
  input  logic [DUR_W-1:0]             duration,
  output logic [NUM_VOICES-1:0]        voice_load,
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic                         all_idle
);
  import music_pkg::*;

  logic [NUM_VOICES-1:0]             active, active_nxt, load_vec, load_pulse, free_oh;
  logic [NUM_VOICES-1:0][NOTE_W-1:0] notes;
  logic any_free, silent, accept, place, tick, found;

  assign tick     = beat && play;
  assign any_free = |(~active);
  assign silent   = (note == NOTE_W'(REST_NOTE)) || (duration == '0);

  // Free-voice priority encoder, lowest index first.
  always_comb begin
    free_oh = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!active[i] && !found) begin
        free_oh[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

`ifdef VOICE_STEAL_EN
  logic [NUM_VOICES-1:0][DUR_W-1:0] rem;
  logic [NUM_VOICES-1:0]            steal_oh;
  logic [DUR_W-1:0]                 best;

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    steal_oh    = '0;
    steal_oh[0] = 1'b1;
    best        = rem[0];
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (rem[i] < best) begin
        best        = rem[i];
        steal_oh    = '0;
        steal_oh[i] = 1'b1;
      end
    end
  end

  assign note_ready = play && !flush;
  assign load_vec   = place ? (any_free ? free_oh : steal_oh) : '0;
`else
  assign note_ready = play && !flush && (any_free || silent);
  assign load_vec   = place ? free_oh : '0;
`endif

  assign accept = note_valid && note_ready;
  assign place  = accept && !silent;

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    voice_slot #(.NOTE_W(NOTE_W), .DUR_W(DUR_W)) u_slot (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .load       (load_vec[i]),
      .tick       (tick),
      .note_in    (note),
      .dur_in     (duration),
`ifdef VOICE_STEAL_EN
      .rem_out    (rem[i]),
`endif
      .active     (active[i]),
      .active_nxt (active_nxt[i]),
      .load_pulse (load_pulse[i]),
      .note       (notes[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) all_idle <= 1'b1;
    else       all_idle <= ~|active_nxt;
  end

  assign voice_active = active;
  assign voice_load   = load_pulse;
  assign voice_note   = notes;
endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
Schedules notes from the song reader onto a fixed pool of NUM_VOICES note-player voices so chords and overlapping notes share the limited synthesis resources. Tracks remaining beats per voice, frees voices on expiry, and back-pressures the song reader when the pool is full. Sits between song_reader and the note_player bank inside music_player, driven by the beat generator and the play/next control.

Parameters:
NUM_VOICES, 4, number of note-player voices managed (1..8)
NOTE_W, 6, note index width; note 0 is a rest
DUR_W, 6, duration width in beats

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
play  input  1  1 = playing; 0 = paused (all state frozen)
flush  input  1  one-cycle pulse on song change; clears all voices
beat  input  1  one-cycle beat tick
note_valid  input  1  song reader offers a note
note_ready  output  1  allocator accepts offered note this cycle
note  input  NOTE_W  offered note index
duration  input  DUR_W  offered duration in beats
voice_load  output  NUM_VOICES  one-cycle pulse: voice i just loaded a new note
voice_active  output  NUM_VOICES  voice i currently sounding
voice_note  output  NUM_VOICES*NOTE_W  packed note per voice, voice i at [i*NOTE_W +: NOTE_W]
all_idle  output  1  no voice active

Behaviour:
- Clock is clk. Reset is synchronous and active-high. All outputs are registered except note_ready.
- Reset: voice_active=0, voice_note=0, voice_load=0, all_idle=1, and all remaining counters=0.
- Priority per edge: reset > flush > normal operation.
- Handshake: a note is accepted when note_valid && note_ready at a rising edge.
- note_ready is combinational from registered state: play && !flush && (any voice free || note==0 || duration==0).
- Rest and zero-duration notes (note==0 or duration==0) are accepted and discarded. No voice is loaded.
- Allocation: an accepted note goes to the lowest-index free voice. On that edge:
  - remaining[i] <= duration
  - voice_note[i] <= note
  - voice_active[i] <= 1
  - voice_load[i] <= 1 for exactly one cycle, so the pulse is visible in the cycle after acceptance, aligned with the new voice_note.
- Beat: on beat && play, each active voice with remaining>1 decrements. An active voice with remaining==1 clears voice_active and sets remaining=0. voice_note holds its last value.
- Simultaneous accept + beat: the newly loaded voice is not decremented that edge. A voice freed by this beat is not eligible for allocation until the next cycle, because eligibility comes from registered state.
- Pause (play=0): beat is ignored, no decrement, note_ready=0, outputs hold.
- flush: all voice_active and remaining are cleared, voice_load=0, and note_ready=0 in the flush cycle. voice_note holds.
- all_idle is registered and equals ~|voice_active of the next state.
- Reset asserted mid-note: state returns to reset values on that edge. Any pending handshake is dropped.

Optional Feature:
VOICE_STEAL_EN
- Defined: when no voice is free, a non-rest note still gets note_ready = play && !flush. It replaces the active voice with the smallest remaining count (lowest index breaks ties). That voice gets voice_load pulsed and its remaining reloaded.
- Undefined: when the pool is full, note_ready stays low until a voice frees.

Decomposition:
- Package music_pkg holds:
  - NOTE_W and DUR_W constants
  - note_t and dur_t typedefs
  - REST_NOTE = 0
- Sub-module voice_slot: one per voice. Holds the note register, remaining counter, active flag and load pulse, with load/tick/flush inputs.
- voice_allocator itself holds the free-voice priority encoder, the steal selector and the handshake.

Test Plan:
1. Reset, play=1: offer note 10 with duration 3 -> accepted the same cycle. Next cycle voice_load=0001, voice_note[0]=10, all_idle=0. After 3 beats, voice_active=0000 and all_idle=1.
2. Offer four notes (5, 6, 7, 8) with duration 4 back-to-back -> voices 0..3 loaded in order. A fifth offer (note 9) sees note_ready=0 until the next beat after expiry (steal disabled).
3. Offer note 0 with duration 4 and note 12 with duration 0 -> both accepted, voice_load stays 0000, all_idle stays 1.
4. With voice 0 at remaining 1, assert beat and offer note 20 in the same cycle while voices 1..3 are busy -> note_ready=0. Voice 0 frees. Next cycle the note is accepted into voice 0.
5. Play=0 with voice 1 at remaining 2, pulse beat 3 times -> remaining still 2 and note_ready=0. Set play=1 and give 2 beats -> voice 1 frees.
6. With all four voices active, pulse flush -> next cycle voice_active=0000 and all_idle=1. With VOICE_STEAL_EN defined, a full pool at remaining {3,1,2,1} plus note 30 -> voice 1 reloaded and voice_load=0010.
